// File: rtl/conv_frame_arbiter_if.sv
// Bundle of requester, result and engine handshake signals around conv_frame_arbiter.
// The arbiter connects through the slave modport; the surrounding environment uses master.
interface conv_frame_arbiter_if #(
  parameter int T = 16
);
  logic        [T-1:0] s0_data_in_x;
  logic                s0_valid_x;
  logic                s0_ready_x;
  logic        [T-1:0] s1_data_in_x;
  logic                s1_valid_x;
  logic                s1_ready_x;
  logic signed [T-1:0] m0_data_out_y;
  logic                m0_valid_y;
  logic                m0_ready_y;
  logic signed [T-1:0] m1_data_out_y;
  logic                m1_valid_y;
  logic                m1_ready_y;
  logic        [T-1:0] e_data_out_x;
  logic                e_valid_x;
  logic                e_ready_x;
  logic signed [T-1:0] e_data_in_y;
  logic                e_valid_y;
  logic                e_ready_y;

  modport slave (
    input  s0_data_in_x, s0_valid_x, output s0_ready_x,
    input  s1_data_in_x, s1_valid_x, output s1_ready_x,
    output m0_data_out_y, m0_valid_y, input  m0_ready_y,
    output m1_data_out_y, m1_valid_y, input  m1_ready_y,
    output e_data_out_x, e_valid_x, input  e_ready_x,
    input  e_data_in_y, e_valid_y, output e_ready_y
  );

  modport master (
    output s0_data_in_x, s0_valid_x, input  s0_ready_x,
    output s1_data_in_x, s1_valid_x, input  s1_ready_x,
    input  m0_data_out_y, m0_valid_y, output m0_ready_y,
    input  m1_data_out_y, m1_valid_y, output m1_ready_y,
    input  e_data_out_x, e_valid_x, output e_ready_x,
    output e_data_in_y, e_valid_y, input  e_ready_y
  );
endinterface

// File: rtl/conv_frame_arbiter.sv
// Round-robin, frame-granular sharing of one convolution engine between two requesters.
// A small tag FIFO remembers the owner of each in-flight frame so results are steered back correctly.
module conv_frame_arbiter #(
  parameter int T        = 16,
  parameter int N        = 128,
  parameter int M        = 8,
  parameter int TAGDEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  conv_frame_arbiter_if.slave bus
);
  localparam int NOUT = N - M + 1;
  localparam int IW   = $clog2(N);
  localparam int OW   = $clog2(NOUT);
  localparam int PW   = (TAGDEPTH > 1) ? $clog2(TAGDEPTH) : 1;
  localparam int CW   = $clog2(TAGDEPTH + 1);

  typedef enum logic {IDLE, FEED} state_t;

  state_t        state;
  logic          grant;
  logic          last_grant;
  logic [IW-1:0] in_cnt;
  logic [OW-1:0] out_cnt;
  logic          tag_mem [TAGDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] occ;

  logic fifo_empty;
  logic fifo_full;
  logic head;
  logic pick;
  logic do_grant;
  logic sel_valid;
  logic in_xfer;
  logic in_last;
  logic out_xfer;
  logic out_last;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(TAGDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    fifo_empty = (occ == '0);
    fifo_full  = (occ == CW'(TAGDEPTH));
    head       = tag_mem[rd_ptr];

    // Round robin only matters on a tie; a lone requester always wins.
    if (bus.s0_valid_x && bus.s1_valid_x) pick = ~last_grant;
    else                                  pick = bus.s1_valid_x;
    do_grant = (state == IDLE) && !fifo_full && (bus.s0_valid_x || bus.s1_valid_x);

    sel_valid = grant ? bus.s1_valid_x : bus.s0_valid_x;
    in_xfer   = !reset && (state == FEED) && sel_valid && bus.e_ready_x;
    in_last   = in_xfer && (in_cnt == IW'(N - 1));

    bus.e_data_out_x = grant ? bus.s1_data_in_x : bus.s0_data_in_x;
    bus.e_valid_x    = !reset && (state == FEED) && sel_valid;
    bus.s0_ready_x   = !reset && (state == FEED) && !grant && bus.e_ready_x;
    bus.s1_ready_x   = !reset && (state == FEED) &&  grant && bus.e_ready_x;

    // Result side is steered purely by the owner tag at the FIFO head.
    bus.m0_data_out_y = bus.e_data_in_y;
    bus.m1_data_out_y = bus.e_data_in_y;
    bus.m0_valid_y    = !reset && !fifo_empty && !head && bus.e_valid_y;
    bus.m1_valid_y    = !reset && !fifo_empty &&  head && bus.e_valid_y;
    bus.e_ready_y     = !reset && !fifo_empty && (head ? bus.m1_ready_y : bus.m0_ready_y);

    out_xfer = !reset && !fifo_empty && bus.e_valid_y && bus.e_ready_y;
    out_last = out_xfer && (out_cnt == OW'(NOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      in_cnt     <= '0;
      out_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (do_grant) begin
            state  <= FEED;
            grant  <= pick;
            in_cnt <= '0;
          end
        end
        FEED: begin
          if (in_xfer) begin
            if (in_last) begin
              state      <= IDLE;
              last_grant <= grant;
              in_cnt     <= '0;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Push and pop may coincide; occupancy then stays put.
      if (do_grant) begin
        tag_mem[wr_ptr] <= pick;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (out_xfer) out_cnt <= out_last ? '0 : out_cnt + 1'b1;
      if (out_last) rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + CW'(do_grant) - CW'(out_last);
    end
  end
endmodule

// File: tb/tb_conv_frame_arbiter.sv
// Directed and randomized bench for conv_frame_arbiter with a behavioural engine and
// per-requester expected-result queues derived from whole frames.
module tb_conv_frame_arbiter;
  localparam int T        = 16;
  localparam int N        = 128;
  localparam int M        = 8;
  localparam int TAGDEPTH = 2;
  localparam int NOUT     = N - M + 1;

  typedef logic [T-1:0] frame_t [N];

  logic clk;
  logic reset;

  conv_frame_arbiter_if #(.T(T)) bus ();

  conv_frame_arbiter #(.T(T), .N(N), .M(M), .TAGDEPTH(TAGDEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        [T-1:0] src0_q[$];
  logic        [T-1:0] src1_q[$];
  logic signed [T-1:0] exp0_q[$];
  logic signed [T-1:0] exp1_q[$];
  logic        [T-1:0] eng_in[$];
  logic signed [T-1:0] eng_out[$];
  int                  grant_log[$];

  int pv0, pv1, pex, pey, pmr0, pmr1;
  int in_words;
  bit frame_owner;
  int cyc;
  int last_in_cyc;
  int first_in_cyc;
  int words_acc;
  bit m1_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Golden FIR: y[j] = sum_i h[i]*x[j+i], h[i] = i-3, wrapped to T bits.
  function automatic logic signed [T-1:0] conv_at(input frame_t f, input int j);
    int acc;
    acc = 0;
    for (int i = 0; i < M; i++) acc += (i - 3) * int'(f[j + i]);
    return acc[T-1:0];
  endfunction

  task automatic load_frame(input int r, input bit ramp);
    frame_t f;
    for (int k = 0; k < N; k++) f[k] = ramp ? T'(k) : T'($urandom);
    for (int k = 0; k < N; k++) begin
      if (r == 0) src0_q.push_back(f[k]);
      else        src1_q.push_back(f[k]);
    end
    for (int j = 0; j < NOUT; j++) begin
      if (r == 0) exp0_q.push_back(conv_at(f, j));
      else        exp1_q.push_back(conv_at(f, j));
    end
  endtask

  task automatic set_p(input int v0, input int v1, input int ex, input int ey,
                       input int mr0, input int mr1);
    pv0 = v0; pv1 = v1; pex = ex; pey = ey; pmr0 = mr0; pmr1 = mr1;
  endtask

  function automatic logic roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  // One clock: drive after negedge, sample handshakes before posedge, update models after it.
  task automatic step();
    logic s0x, s1x, ex, ey, m0x, m1x;
    logic        [T-1:0] xd, w;
    logic signed [T-1:0] yd0, yd1;
    frame_t ef;
    bus.s0_valid_x   = (src0_q.size() > 0) && roll(pv0);
    bus.s0_data_in_x = (src0_q.size() > 0) ? src0_q[0] : '0;
    bus.s1_valid_x   = (src1_q.size() > 0) && roll(pv1);
    bus.s1_data_in_x = (src1_q.size() > 0) ? src1_q[0] : '0;
    bus.e_ready_x    = roll(pex);
    bus.e_valid_y    = (eng_out.size() > 0) && roll(pey);
    bus.e_data_in_y  = (eng_out.size() > 0) ? eng_out[0] : '0;
    bus.m0_ready_y   = roll(pmr0);
    bus.m1_ready_y   = roll(pmr1);
    #1;
    s0x = bus.s0_valid_x && bus.s0_ready_x;
    s1x = bus.s1_valid_x && bus.s1_ready_x;
    ex  = bus.e_valid_x && bus.e_ready_x;
    ey  = bus.e_valid_y && bus.e_ready_y;
    m0x = bus.m0_valid_y && bus.m0_ready_y;
    m1x = bus.m1_valid_y && bus.m1_ready_y;
    if (bus.m1_valid_y) m1_seen = 1'b1;
    xd  = bus.e_data_out_x;
    yd0 = bus.m0_data_out_y;
    yd1 = bus.m1_data_out_y;
    @(posedge clk);
    #1;
    if (ex || s0x || s1x) chk("ex_match", ex, s0x | s1x);
    if (s0x && s1x) chk("one_src", 2, 1);
    else if (s0x || s1x) begin
      w = s1x ? src1_q.pop_front() : src0_q.pop_front();
      chk("ex_data", xd, w);
      if (first_in_cyc < 0) first_in_cyc = cyc;
      if (in_words == 0) begin
        frame_owner = s1x;
        grant_log.push_back(int'(s1x));
      end else begin
        chk("frame_owner", s1x, frame_owner);
      end
      words_acc++;
      if (in_words == N - 1) begin
        in_words    = 0;
        last_in_cyc = cyc;
      end else begin
        in_words++;
      end
      eng_in.push_back(w);
      if (eng_in.size() == N) begin
        for (int k = 0; k < N; k++) ef[k] = eng_in[k];
        for (int j = 0; j < NOUT; j++) eng_out.push_back(conv_at(ef, j));
        eng_in.delete();
      end
    end
    if (ey || m0x || m1x) chk("ey_match", ey, m0x | m1x);
    if (ey) void'(eng_out.pop_front());
    if (m0x) begin
      chk("m0_extra", exp0_q.size() > 0, 1);
      if (exp0_q.size() > 0) chk("m0_data", yd0, exp0_q.pop_front());
    end
    if (m1x) begin
      chk("m1_extra", exp1_q.size() > 0, 1);
      if (exp1_q.size() > 0) chk("m1_data", yd1, exp1_q.pop_front());
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset(input int cyc_n);
    reset = 1'b1;
    bus.s0_valid_x = 1'b1; bus.s0_data_in_x = '0;
    bus.s1_valid_x = 1'b1; bus.s1_data_in_x = '0;
    bus.e_ready_x  = 1'b1; bus.e_valid_y    = 1'b1; bus.e_data_in_y = '0;
    bus.m0_ready_y = 1'b1; bus.m1_ready_y   = 1'b1;
    for (int i = 0; i < cyc_n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_outs", {bus.s0_ready_x, bus.s1_ready_x, bus.e_valid_x,
                       bus.e_ready_y, bus.m0_valid_y, bus.m1_valid_y}, 6'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    src0_q.delete(); src1_q.delete(); exp0_q.delete(); exp1_q.delete();
    eng_in.delete(); eng_out.delete();
    in_words = 0;
  endtask

  task automatic run_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((src0_q.size() + src1_q.size() + exp0_q.size() + exp1_q.size() + eng_out.size()) != 0
           && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done"}, n < budget, 1);
    chk({tag, "_exp0_left"}, exp0_q.size(), 0);
    chk({tag, "_exp1_left"}, exp1_q.size(), 0);
  endtask

  initial begin
    int g0, n, f0;
    in_words = 0; cyc = 0; words_acc = 0; m1_seen = 1'b0;
    first_in_cyc = -1; last_in_cyc = -1;
    set_p(0, 0, 100, 100, 100, 100);
    apply_reset(3);

    // Single ramp frame from s0 only.
    load_frame(0, 1'b1);
    set_p(100, 0, 100, 100, 100, 100);
    cyc = 0; first_in_cyc = -1; m1_seen = 1'b0;
    run_drain("t1", 1000);
    chk("t1_grant_lat", first_in_cyc, 1);
    chk("t1_m1_seen", m1_seen, 0);

    // Both requesters saturating: strict alternation and one bubble per frame.
    apply_reset(1);
    for (int i = 0; i < 4; i++) begin
      load_frame(0, 1'b0);
      load_frame(1, 1'b0);
    end
    set_p(100, 100, 100, 100, 100, 100);
    g0 = grant_log.size();
    cyc = 0; last_in_cyc = -1;
    run_drain("t2", 3000);
    chk("t2_grants", grant_log.size() - g0, 8);
    for (int i = 0; i < 8; i++)
      if (g0 + i < grant_log.size()) chk("t2_rr_order", grant_log[g0 + i], i % 2);
    chk("t2_last_in_cyc", last_in_cyc, 8 * (N + 1) - 1);

    // Result sinks stalled: exactly TAGDEPTH frames accepted, then resume.
    for (int i = 0; i < 3; i++) begin
      load_frame(0, 1'b0);
      load_frame(1, 1'b0);
    end
    set_p(100, 100, 100, 100, 0, 0);
    g0 = grant_log.size();
    words_acc = 0;
    for (int i = 0; i < 400; i++) step();
    chk("t3_words_stalled", words_acc, TAGDEPTH * N);
    set_p(100, 100, 100, 100, 100, 100);
    cyc = 0; first_in_cyc = -1;
    for (int i = 0; i < 130; i++) step();
    chk("t3_resume_cyc", first_in_cyc, NOUT + 1);
    run_drain("t3", 3000);
    chk("t3_grants", grant_log.size() - g0, 6);
    if (grant_log.size() - g0 >= 3) begin
      chk("t3_g0", grant_log[g0], 0);
      chk("t3_g1", grant_log[g0 + 1], 1);
      chk("t3_g2", grant_log[g0 + 2], 0);
    end

    // Reset in the middle of a frame, then a fresh s1 frame.
    load_frame(0, 1'b1);
    set_p(100, 0, 100, 100, 100, 100);
    n = 0;
    while (in_words < 60 && n < 500) begin
      step();
      n++;
    end
    chk("t4_reach60", in_words, 60);
    apply_reset(2);
    load_frame(1, 1'b0);
    set_p(0, 100, 100, 100, 100, 100);
    g0 = grant_log.size();
    run_drain("t4", 1000);
    chk("t4_grants", grant_log.size() - g0, 1);
    if (grant_log.size() > g0) chk("t4_owner", grant_log[g0], 1);

    // Random handshakes on every port, 78 frames split between requesters.
    f0 = $urandom_range(58, 20);
    for (int i = 0; i < f0; i++) load_frame(0, 1'b0);
    for (int i = 0; i < 78 - f0; i++) load_frame(1, 1'b0);
    set_p(75, 75, 80, 80, 75, 75);
    g0 = grant_log.size();
    words_acc = 0;
    run_drain("t6", 60000);
    chk("t6_frames", grant_log.size() - g0, 78);
    chk("t6_words", words_acc, 78 * N);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
